// File: rtl/stopwatch_ctrl_if.sv
// Control/status bundle between the stopwatch controller (slave) and the
// board side: buttons, time counter and display latch (master).
interface stopwatch_ctrl_if;
  logic       start_n;
  logic       lap_n;
  logic       at_max;
  logic       tick;
  logic       clear;
  logic       snap;
  logic       hold;
  logic [1:0] state;

  modport master (
    output start_n, lap_n, at_max,
    input  tick, clear, snap, hold, state
  );

  modport slave (
    input  start_n, lap_n, at_max,
    output tick, clear, snap, hold, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: button synchronisers, tick prescaler and
// the run/pause/lap/clear state machine, all on the single system clock.
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 50_000_000,
  parameter bit AUTO_STOP = 1'b1
) (
  input logic             clk,
  input logic             rst,
  stopwatch_ctrl_if.slave bus
);

  localparam int            PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    LAP   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] prescale;
  logic          tick_q;
  logic          clear_q;
  logic          snap_q;
  logic          hold_q;

  logic [1:0] start_sync;
  logic [1:0] lap_sync;
  logic       start_prev;
  logic       lap_prev;
  logic       start_press;
  logic       lap_press;
  logic       counting;
  logic       wrap;
  logic       stop_now;
  logic       resume_blocked;

  // Reset to "pressed" so a button held through reset must be released first.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_sync <= 2'b00;
      lap_sync   <= 2'b00;
      start_prev <= 1'b0;
      lap_prev   <= 1'b0;
    end else begin
      start_sync <= {start_sync[0], bus.start_n};
      lap_sync   <= {lap_sync[0], bus.lap_n};
      start_prev <= start_sync[1];
      lap_prev   <= lap_sync[1];
    end
  end

  assign start_press    = start_prev & ~start_sync[1];
  assign lap_press      = lap_prev & ~lap_sync[1];
  assign counting       = (state == RUN) || (state == LAP);
  assign wrap           = counting && (prescale == LAST);
  assign stop_now       = AUTO_STOP && wrap && bus.at_max;
  assign resume_blocked = AUTO_STOP && bus.at_max;

  // Start beats lap on a simultaneous press; auto-stop beats both.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prescale <= '0;
      tick_q   <= 1'b0;
      clear_q  <= 1'b0;
      snap_q   <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      tick_q  <= 1'b0;
      clear_q <= 1'b0;
      snap_q  <= 1'b0;

      if (counting) begin
        prescale <= wrap ? '0 : prescale + PW'(1);
      end
      if (wrap && !stop_now) begin
        tick_q <= 1'b1;
      end

      case (state)
        IDLE: begin
          prescale <= '0;
          if (start_press) begin
            state <= RUN;
          end else if (lap_press) begin
            clear_q <= 1'b1;
          end
        end
        RUN: begin
          if (stop_now || start_press) begin
            state <= PAUSE;
          end else if (lap_press) begin
            state  <= LAP;
            snap_q <= 1'b1;
            hold_q <= 1'b1;
          end
        end
        LAP: begin
          if (stop_now || start_press) begin
            state  <= PAUSE;
            hold_q <= 1'b0;
          end else if (lap_press) begin
            state  <= RUN;
            hold_q <= 1'b0;
          end
        end
        PAUSE: begin
          if (start_press) begin
            if (!resume_blocked) begin
              state <= RUN;
            end
          end else if (lap_press) begin
            state    <= IDLE;
            prescale <= '0;
            clear_q  <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          hold_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tick  = tick_q;
  assign bus.clear = clear_q;
  assign bus.snap  = snap_q;
  assign bus.hold  = hold_q;
  assign bus.state = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl at TICK_DIV=4: expected tick/snap/clear
// edges are queued when presses are scheduled and popped as the pulses appear.
module tb_stopwatch_ctrl;

  localparam int TD = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   failures;
  int   phase;

  int tick_q[$];
  int snap_q[$];
  int clear_q[$];

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.TICK_DIV(TD), .AUTO_STOP(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sw_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc holds the index of the most recent rising edge
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic waitCycle(input int target);
    if (cyc > target) checkOutput("schedule", cyc, target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic scheduleTicks(input int r, input int p, input int stop, output int v);
    for (int t = r + (TD - p); t <= stop; t += TD) tick_q.push_back(t);
    v = (p + stop - r) % TD;
  endtask

  // Buttons low from edge e through e+2; state changes at e+2.
  task automatic applyStimulus(input int e, input bit s, input bit l,
                               input int pre, input int post);
    waitCycle(e - 1);
    if (s) sw_if.start_n = 1'b0;
    if (l) sw_if.lap_n = 1'b0;
    waitCycle(e + 1);
    checkOutput("pre_state", int'(sw_if.state), pre);
    waitCycle(e + 2);
    checkOutput("post_state", int'(sw_if.state), post);
    checkOutput("hold", int'(sw_if.hold), (post == 2) ? 1 : 0);
    sw_if.start_n = 1'b1;
    sw_if.lap_n   = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sw_if.tick === 1'b1) begin
      if (tick_q.size() == 0) checkOutput("tick_unexpected", cyc, -1);
      else checkOutput("tick_edge", cyc, tick_q.pop_front());
    end
    if (sw_if.snap === 1'b1) begin
      if (snap_q.size() == 0) checkOutput("snap_unexpected", cyc, -1);
      else checkOutput("snap_edge", cyc, snap_q.pop_front());
    end
    if (sw_if.clear === 1'b1) begin
      if (clear_q.size() == 0) checkOutput("clear_unexpected", cyc, -1);
      else checkOutput("clear_edge", cyc, clear_q.pop_front());
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish, edge %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests    = 0;
    failures = 0;
    rst      = 1'b1;
    sw_if.start_n = 1'b0;
    sw_if.lap_n   = 1'b1;
    sw_if.at_max  = 1'b0;

    @(negedge clk);
    waitCycle(3);
    checkOutput("rst_state", int'(sw_if.state), 0);
    checkOutput("rst_tick", int'(sw_if.tick), 0);
    checkOutput("rst_clear", int'(sw_if.clear), 0);
    checkOutput("rst_snap", int'(sw_if.snap), 0);
    checkOutput("rst_hold", int'(sw_if.hold), 0);
    rst = 1'b0;

    // start held through reset must not register
    waitCycle(8);
    checkOutput("held_no_press", int'(sw_if.state), 0);
    sw_if.start_n = 1'b1;

    // run three ticks, pause with phase 2
    scheduleTicks(16, 0, 30, phase);
    checkOutput("pause_phase", phase, 2);
    applyStimulus(14, 1, 0, 0, 1);
    applyStimulus(28, 1, 0, 1, 3);
    waitCycle(40);
    checkOutput("pause_state", int'(sw_if.state), 3);

    // resume, lap, lap, pause (wrap on the pause edge still ticks)
    scheduleTicks(50, 2, 72, phase);
    applyStimulus(48, 1, 0, 3, 1);
    snap_q.push_back(57);
    applyStimulus(55, 0, 1, 1, 2);
    waitCycle(61);
    checkOutput("lap_hold", int'(sw_if.hold), 1);
    applyStimulus(63, 0, 1, 2, 1);
    applyStimulus(70, 1, 0, 1, 3);

    // clear from pause, fresh start, simultaneous press
    clear_q.push_back(82);
    applyStimulus(80, 0, 1, 3, 0);
    scheduleTicks(92, 0, 103, phase);
    applyStimulus(90, 1, 0, 0, 1);
    applyStimulus(101, 1, 1, 1, 3);
    clear_q.push_back(112);
    applyStimulus(110, 0, 1, 3, 0);

    // auto-stop at the maximum count
    tick_q.push_back(126);
    applyStimulus(120, 1, 0, 0, 1);
    waitCycle(127);
    sw_if.at_max = 1'b1;
    waitCycle(129);
    checkOutput("autostop_pre", int'(sw_if.state), 1);
    waitCycle(130);
    checkOutput("autostop_state", int'(sw_if.state), 3);
    applyStimulus(140, 1, 0, 3, 3);
    waitCycle(150);
    sw_if.at_max = 1'b0;
    scheduleTicks(154, 0, 167, phase);
    applyStimulus(152, 1, 0, 3, 1);
    snap_q.push_back(162);
    applyStimulus(160, 0, 1, 1, 2);
    applyStimulus(165, 1, 0, 2, 3);
    waitCycle(170);
    sw_if.at_max = 1'b1;
    clear_q.push_back(177);
    applyStimulus(175, 0, 1, 3, 0);
    waitCycle(180);
    sw_if.at_max = 1'b0;

    // reset while in LAP
    scheduleTicks(192, 0, 200, phase);
    applyStimulus(190, 1, 0, 0, 1);
    snap_q.push_back(197);
    applyStimulus(195, 0, 1, 1, 2);
    waitCycle(200);
    rst = 1'b1;
    waitCycle(201);
    checkOutput("midrst_state", int'(sw_if.state), 0);
    checkOutput("midrst_tick", int'(sw_if.tick), 0);
    checkOutput("midrst_hold", int'(sw_if.hold), 0);
    waitCycle(202);
    rst = 1'b0;

    scheduleTicks(212, 0, 219, phase);
    applyStimulus(210, 1, 0, 0, 1);
    waitCycle(219);

    checkOutput("ticks_pending", tick_q.size(), 0);
    checkOutput("snaps_pending", snap_q.size(), 0);
    checkOutput("clears_pending", clear_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Single-clock sequencing controller for the stopwatch datapath. It runs on the 50 MHz board clock and replaces the 1 Hz-clocked control path. It synchronises the debounced Start/Pause and Lap/Reset buttons and runs the run/pause/lap/clear state machine. It generates a one-cycle count-enable tick for the time counter and the clear, snapshot and hold controls for the display latch feeding the 7-segment driver.

## Interface
- TICK_DIV, 50_000_000: clock cycles per count tick; legal range is 2 or more.
- AUTO_STOP, 1: when 1, counting halts at the counter's maximum value instead of wrapping.
- clk  in  1  50 MHz system clock.
- rst  in  1  synchronous reset, active high.
- start_n  in  1  debounced Start/Pause button level, active low, asynchronous to clk.
- lap_n  in  1  debounced Lap/Reset button level, active low, asynchronous to clk.
- at_max  in  1  high while the time counter holds its maximum value (99:59).
- tick  out  1  one-cycle count enable to the time counter.
- clear  out  1  one-cycle synchronous clear to the time counter and the display latch.
- snap  out  1  one-cycle load of the display latch from the live count.
- hold  out  1  level signal; when high, the display shows the latched value instead of the live count.
- state  out  2  current state: 0 = IDLE, 1 = RUN, 2 = LAP, 3 = PAUSE.

## Operation
- Input path:
  - Each button passes through a 2-flop synchroniser, then a falling-edge detector.
  - A press is a single-cycle event.
  - On reset, every synchroniser flop and edge-detect flop is set to 0 ("pressed"). A button held through reset therefore produces no press until it is released and pressed again.
- Prescaler:
  - Counts 0..TICK_DIV-1 and is ceil(log2(TICK_DIV)) bits wide.
  - Increments only in RUN and LAP.
  - Holds its value in PAUSE, so sub-second phase is preserved across pause/resume.
  - Forced to 0 in IDLE and whenever clear is issued.
  - When it wraps from TICK_DIV-1 to 0, the next-cycle tick is 1.
- FSM transitions (s = start press, l = lap press):
  - IDLE: s -> RUN. l -> IDLE and issue clear.
  - RUN: s -> PAUSE. l -> LAP and issue snap.
  - LAP: l -> RUN (display goes live again). s -> PAUSE.
  - PAUSE: s -> RUN. l -> IDLE and issue clear.
- Simultaneous presses: when s and l occur in the same cycle, s wins and l is discarded.
- hold is 1 only in LAP. Counting continues underneath while hold is 1.
- Auto-stop (AUTO_STOP=1):
  - If a prescaler wrap occurs while at_max=1, tick is suppressed and the state goes to PAUSE; the prescaler is 0 after the wrap.
  - In PAUSE with at_max=1, s is ignored.
  - l still clears, as normal.
- AUTO_STOP=0: at_max is ignored and the counter wraps on its own.

## Timing
- Reset values: tick=0, clear=0, snap=0, hold=0, state=0 (IDLE), prescaler=0.
- Press latency: with the button first sampled low at edge E, state, hold, clear and snap update at edge E+2. The clear and snap pulses are high for exactly the cycle after E+2.
- All outputs are registered; no combinational path exists from inputs to outputs.
- First tick after entering RUN from IDLE at edge E is high from E+TICK_DIV to E+TICK_DIV+1.
- Subsequent ticks are exactly TICK_DIV cycles apart.
- PAUSE entered at edge P with prescaler value v; resume at edge R. The next tick is high from edge R+(TICK_DIV-v) for one cycle.
- A wrap coinciding with the pause-transition edge still produces its tick. The prescaler is not incremented in the state being entered.
- rst asserted mid-operation: all state and outputs return to reset values at the next edge. Any pulse in progress is truncated.
- A tick and a snap may be high in the same cycle. The display latch must capture the pre-tick count.

## Test plan
- Reset with start_n held low, then release and press at TICK_DIV=4: no transition until the release; after the press, state=1 at E+2 and the first tick is 4 cycles later.
- RUN 3 ticks, press start, wait 20 cycles, press start (TICK_DIV=4, prescaler v=2): no ticks while in PAUSE; the next tick arrives 2 cycles after the resume edge.
- RUN, press lap: state=2, snap high for 1 cycle, hold=1, ticks continue. Press lap again: state=1, hold=0.
- PAUSE, press lap: clear high for 1 cycle, state=0, prescaler=0. A later start produces its first tick after exactly TICK_DIV cycles.
- start and lap pressed in the same cycle from RUN: state=3, no snap.
- AUTO_STOP=1, at_max=1 in RUN: at the wrap, no tick and state=3. A start press stays in PAUSE; a lap press clears to IDLE.
